// File: rtl/gc_pkg.sv
// Shared constants, register offsets and state encoding for the GameCube
// controller poll transmitter.
package gc_pkg;
  localparam logic [23:0] GC_POLL_CMD   = 24'h400300;
  localparam int          GC_CMD_BITS   = 24;
  localparam int          GC_BIT_US     = 4;
  localparam logic [2:0]  GC_CTRL_OFS   = 3'h0;
  localparam logic [2:0]  GC_STATUS_OFS = 3'h4;

  typedef enum logic [2:0] {IDLE, LOAD, TX_LOW, TX_HIGH, STOP, RX} gc_state_t;
endpackage

// File: rtl/gc_us_timer.sv
// Loadable microsecond down-counter; done is high on the last cycle of the
// loaded interval, so a state entered with load lasts exactly load_us us.
module gc_us_timer #(
  parameter int CYCLES_PER_US = 100,
  parameter int US_W          = 9
) (
  input  logic            PCLK,
  input  logic            rst,
  input  logic            load,
  input  logic [US_W-1:0] load_us,
  output logic            done
);
  localparam int CW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;

  logic [CW-1:0]   cyc_cnt;
  logic [US_W-1:0] us_cnt;
  logic            running;

  assign done = running && (cyc_cnt == '0) && (us_cnt == '0);

  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cyc_cnt <= '0;
      us_cnt  <= '0;
    end else if (load) begin
      running <= 1'b1;
      us_cnt  <= load_us - US_W'(1);
      cyc_cnt <= CW'(CYCLES_PER_US - 1);
    end else if (done) begin
      running <= 1'b0;
    end else if (running) begin
      if (cyc_cnt == '0) begin
        cyc_cnt <= CW'(CYCLES_PER_US - 1);
        us_cnt  <= us_cnt - US_W'(1);
      end else begin
        cyc_cnt <= cyc_cnt - CW'(1);
      end
    end
  end
endmodule

// File: rtl/gc_poll_tx.sv
// Periodic GameCube poll transmitter: sends the 24-bit poll plus stop bit on
// the open-drain line, then holds ready while the controller answers.
module gc_poll_tx
  import gc_pkg::*;
#(
  parameter int CYCLES_PER_US  = 100,
  parameter int POLL_PERIOD_US = 10000,
  parameter int RESP_BITS      = 64,
  parameter int RX_TIMEOUT_US  = 400
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        ready,
  inout  wire         data
);
  localparam int PERIOD_CYC = POLL_PERIOD_US * CYCLES_PER_US;
  localparam int PW   = $clog2(PERIOD_CYC);
  localparam int MAXU = (RX_TIMEOUT_US > GC_BIT_US) ? RX_TIMEOUT_US : GC_BIT_US;
  localparam int US_W = $clog2(MAXU + 1);
  localparam int EW   = $clog2(RESP_BITS + 2);
  localparam int BW   = $clog2(GC_CMD_BITS);
  localparam logic [EW-1:0] LAST_EDGE = EW'(RESP_BITS + 1);

  gc_state_t             state, state_nx;
  logic                  drive_low, enable, rumble;
  logic [PW-1:0]         period_cnt;
  logic [GC_CMD_BITS-1:0] shift, cmd;
  logic [BW-1:0]         bit_idx;
  logic [EW-1:0]         edge_cnt;
  logic [7:0]            timeout_cnt;
  logic                  sync1, sync_now, sync_prev;
  logic                  wrap, fall, apb_wr, busy;
  logic                  tmr_load, tmr_done;
  logic [US_W-1:0]       tmr_us;
  logic                  ld_frame, next_bit, edge_inc, to_inc;
  logic                  unused_ok;

  function automatic logic [US_W-1:0] low_us(input logic b);
    return b ? US_W'(1) : US_W'(GC_BIT_US - 1);
  endfunction

  function automatic logic [US_W-1:0] high_us(input logic b);
    return US_W'(GC_BIT_US) - low_us(b);
  endfunction

  assign data      = drive_low ? 1'b0 : 1'bz;
  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign unused_ok = ^{PADDR[31:3], PWDATA[31:2]};
  assign wrap      = (period_cnt == PW'(PERIOD_CYC - 1));
  assign fall      = sync_prev & ~sync_now;
  assign apb_wr    = PSEL & PENABLE & PWRITE;
  assign busy      = (state != IDLE);
  assign cmd       = {GC_POLL_CMD[GC_CMD_BITS-1:1], rumble};

  gc_us_timer #(.CYCLES_PER_US(CYCLES_PER_US), .US_W(US_W)) u_timer (
    .PCLK(PCLK), .rst(PRESERN), .load(tmr_load), .load_us(tmr_us), .done(tmr_done)
  );

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_us   = '0;
    ld_frame = 1'b0;
    next_bit = 1'b0;
    edge_inc = 1'b0;
    to_inc   = 1'b0;
    case (state)
      IDLE: if (wrap && enable) state_nx = LOAD;
      LOAD: begin
        ld_frame = 1'b1;
        tmr_load = 1'b1;
        tmr_us   = low_us(cmd[GC_CMD_BITS-1]);
        state_nx = TX_LOW;
      end
      TX_LOW: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_us   = high_us(shift[GC_CMD_BITS-1]);
        state_nx = TX_HIGH;
      end
      TX_HIGH: if (tmr_done) begin
        tmr_load = 1'b1;
        if (bit_idx == BW'(GC_CMD_BITS - 1)) begin
          tmr_us   = US_W'(1);
          state_nx = STOP;
        end else begin
          tmr_us   = low_us(shift[GC_CMD_BITS-2]);
          next_bit = 1'b1;
          state_nx = TX_LOW;
        end
      end
      STOP: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_us   = US_W'(RX_TIMEOUT_US);
        state_nx = RX;
      end
      RX: begin
        // once the stop bit has arrived the timer only covers the tail wait
        if (tmr_done) begin
          to_inc   = (edge_cnt != LAST_EDGE);
          state_nx = IDLE;
        end else if (fall && (edge_cnt != LAST_EDGE)) begin
          edge_inc = 1'b1;
          tmr_load = 1'b1;
          tmr_us   = (edge_cnt == LAST_EDGE - EW'(1)) ? US_W'(GC_BIT_US)
                                                      : US_W'(RX_TIMEOUT_US);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      state       <= IDLE;
      drive_low   <= 1'b0;
      ready       <= 1'b0;
      period_cnt  <= '0;
      shift       <= '0;
      bit_idx     <= '0;
      edge_cnt    <= '0;
      timeout_cnt <= '0;
      enable      <= 1'b0;
      rumble      <= 1'b0;
      sync1       <= 1'b1;
      sync_now    <= 1'b1;
      sync_prev   <= 1'b1;
    end else begin
      state      <= state_nx;
      // outputs registered from the next state so they align with the state
      drive_low  <= (state_nx == TX_LOW) || (state_nx == STOP);
      ready      <= (state_nx == RX);
      period_cnt <= wrap ? '0 : period_cnt + PW'(1);
      sync1      <= data;
      sync_now   <= sync1;
      sync_prev  <= sync_now;
      if (ld_frame) begin
        shift   <= cmd;
        bit_idx <= '0;
      end else if (next_bit) begin
        shift   <= shift << 1;
        bit_idx <= bit_idx + BW'(1);
      end
      if (ld_frame)      edge_cnt <= '0;
      else if (edge_inc) edge_cnt <= edge_cnt + EW'(1);
      if (to_inc && (timeout_cnt != 8'hFF)) timeout_cnt <= timeout_cnt + 8'd1;
      if (apb_wr && (PADDR[2:0] == GC_CTRL_OFS)) begin
        enable <= PWDATA[0];
        rumble <= PWDATA[1];
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    case (PADDR[2:0])
      GC_CTRL_OFS:   PRDATA = {30'b0, rumble, enable};
      GC_STATUS_OFS: PRDATA = {16'b0, timeout_cnt, 7'b0, busy};
      default:       PRDATA = '0;
    endcase
  end
endmodule

// File: tb/tb_gc_poll_tx.sv
// Bench for gc_poll_tx: scenario tasks with a behavioural controller model and
// a frame decoder that measures line pulse widths.
module tb_gc_poll_tx;
  localparam int C      = 10;
  localparam int PER_US = 200;
  localparam int RESP   = 64;
  localparam int TO_US  = 400;
  localparam int PERIOD = PER_US * C;

  logic        PCLK = 1'b0;
  logic        PRESERN, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, ready;
  logic        ctl_low;
  wire         data;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  pullup (data);
  assign data = ctl_low ? 1'b0 : 1'bz;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  gc_poll_tx #(.CYCLES_PER_US(C), .POLL_PERIOD_US(PER_US), .RESP_BITS(RESP),
               .RX_TIMEOUT_US(TO_US)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .ready(ready), .data(data)
  );

  function automatic logic [23:0] model_cmd(input logic rum);
    return {8'h40, 8'h03, 7'b0, rum};
  endfunction

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK); PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
    @(negedge PCLK); PENABLE = 1;
    @(negedge PCLK); PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge PCLK); PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
    @(negedge PCLK); PENABLE = 1; #1 d = PRDATA;
    @(negedge PCLK); PSEL = 0; PENABLE = 0;
  endtask

  task automatic wait_level(input logic lvl, input int bound, output int n);
    n = 0;
    while (data !== lvl && n < bound) begin @(negedge PCLK); n++; end
    if (data !== lvl) n = -1;
  endtask

  // Called with the line just seen low; decodes 24 bits and the stop pulse.
  task automatic capture_frame(output logic [23:0] bits, output int bad,
                               output int sum, output logic rdy);
    int lo, hi, st;
    bad = 0; sum = 0; bits = '0;
    for (int i = 0; i < 24; i++) begin
      wait_level(1'b1, 5 * C, lo);
      wait_level(1'b0, 5 * C, hi);
      bits[23 - i] = (lo > 0) && (lo < 2 * C);
      if (!((lo == C && hi == 3 * C) || (lo == 3 * C && hi == C))) bad++;
      sum += lo + hi;
    end
    wait_level(1'b1, 5 * C, st);
    if (st != C) bad++;
    sum += st;
    rdy = ready;
  endtask

  task automatic ctl_respond(output int drops, output int fall_dly);
    int lo;
    drops = 0;
    repeat ($urandom_range(5, 20)) begin
      @(negedge PCLK); if (ready !== 1'b1) drops++;
    end
    for (int k = 0; k < RESP; k++) begin
      lo = ($urandom_range(0, 1) == 1) ? C : 3 * C;
      ctl_low = 1;
      for (int j = 0; j < 4 * C; j++) begin
        @(negedge PCLK);
        if (j == lo - 1) ctl_low = 0;
        if (ready !== 1'b1) drops++;
      end
    end
    ctl_low = 1; fall_dly = 0;
    while (ready === 1'b1 && fall_dly < 8 * C) begin
      @(negedge PCLK); fall_dly++;
      if (fall_dly == C) ctl_low = 0;
    end
    ctl_low = 0;
  endtask

  int rel_cyc;

  task automatic test_reset();
    logic [31:0] r;
    PRESERN = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0; ctl_low = 0;
    repeat (3) @(negedge PCLK);
    total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready); else passed++;
    total++; if (data !== 1'b1) $display("FAIL reset_line got %b want 1", data); else passed++;
    total++; if (PREADY !== 1'b1) $display("FAIL pready got %b want 1", PREADY); else passed++;
    total++; if (PSLVERR !== 1'b0) $display("FAIL pslverr got %b want 0", PSLVERR); else passed++;
    apb_read(32'h0, r);
    total++; if (r !== 32'h0) $display("FAIL reset_ctrl got %h want 0", r); else passed++;
    apb_read(32'h4, r);
    total++; if (r !== 32'h0) $display("FAIL reset_status got %h want 0", r); else passed++;
    @(negedge PCLK); PRESERN = 0; rel_cyc = cyc;
  endtask

  task automatic test_tx_timing();
    logic [23:0] bits; int bad, sum, n; logic rdy;
    apb_write(32'h0, 32'h1);
    wait_level(1'b0, PERIOD + 50, n);
    total++; if (cyc - rel_cyc !== PERIOD + 1)
      $display("FAIL first_frame_start got %0d want %0d", cyc - rel_cyc, PERIOD + 1); else passed++;
    capture_frame(bits, bad, sum, rdy);
    total++; if (bits !== model_cmd(1'b0)) $display("FAIL tx_bits got %h want %h", bits, model_cmd(1'b0)); else passed++;
    total++; if (bad !== 0) $display("FAIL tx_pulse_widths got %0d bad want 0", bad); else passed++;
    total++; if (sum !== 97 * C) $display("FAIL tx_frame_len got %0d want %0d", sum, 97 * C); else passed++;
    total++; if (rdy !== 1'b1) $display("FAIL ready_at_release got %b want 1", rdy); else passed++;
  endtask

  task automatic test_timeout();
    int n; logic [31:0] r;
    n = 0;
    while (ready === 1'b1 && n < TO_US * C + 100) begin @(negedge PCLK); n++; end
    total++; if (n !== TO_US * C) $display("FAIL timeout_ready_len got %0d want %0d", n, TO_US * C); else passed++;
    apb_read(32'h4, r);
    total++; if (r !== 32'h0000_0100) $display("FAIL timeout_status got %h want 00000100", r); else passed++;
  endtask

  task automatic test_rumble_and_response();
    logic [23:0] bits; int bad, sum, n, drops, fdly; logic rdy; logic [31:0] r;
    apb_write(32'h0, 32'h3);
    wait_level(1'b0, 2 * PERIOD + 50, n);
    fork
      capture_frame(bits, bad, sum, rdy);
      begin
        repeat ($urandom_range(200, 700)) @(negedge PCLK);
        apb_write(32'h0, 32'h1);
      end
    join
    total++; if (bits !== model_cmd(1'b1)) $display("FAIL rumble_bits got %h want %h", bits, model_cmd(1'b1)); else passed++;
    total++; if (bad !== 0) $display("FAIL rumble_pulse_widths got %0d bad want 0", bad); else passed++;
    ctl_respond(drops, fdly);
    total++; if (drops !== 0) $display("FAIL resp_ready_drops got %0d want 0", drops); else passed++;
    total++; if (fdly < 4 * C || fdly > 4 * C + 4)
      $display("FAIL resp_ready_fall got %0d want %0d..%0d", fdly, 4 * C, 4 * C + 4); else passed++;
    apb_read(32'h4, r);
    total++; if (r !== 32'h0000_0100) $display("FAIL resp_status got %h want 00000100", r); else passed++;
  endtask

  task automatic test_disable_in_rx();
    logic [23:0] bits; int bad, sum, n, drops, fdly, act; logic rdy; logic [31:0] r;
    wait_level(1'b0, 2 * PERIOD + 50, n);
    capture_frame(bits, bad, sum, rdy);
    total++; if (bits !== model_cmd(1'b0)) $display("FAIL norumble_bits got %h want %h", bits, model_cmd(1'b0)); else passed++;
    apb_write(32'h0, 32'h0);
    ctl_respond(drops, fdly);
    total++; if (drops !== 0) $display("FAIL dis_ready_drops got %0d want 0", drops); else passed++;
    total++; if (fdly < 4 * C || fdly > 4 * C + 4)
      $display("FAIL dis_ready_fall got %0d want %0d..%0d", fdly, 4 * C, 4 * C + 4); else passed++;
    act = 0;
    repeat (3 * PERIOD + 50) begin
      @(negedge PCLK); if (data !== 1'b1 || ready !== 1'b0) act++;
    end
    total++; if (act !== 0) $display("FAIL dis_no_new_frame got %0d active cycles want 0", act); else passed++;
    apb_read(32'h4, r);
    total++; if (r !== 32'h0000_0100) $display("FAIL dis_status got %h want 00000100", r); else passed++;
    apb_read(32'h8, r);
    total++; if (r !== 32'h0) $display("FAIL unmapped_read got %h want 0", r); else passed++;
  endtask

  task automatic test_reset_midframe();
    int n; logic [31:0] r;
    apb_write(32'h0, 32'h1);
    wait_level(1'b0, 2 * PERIOD + 50, n);
    repeat ($urandom_range(1, 20)) @(negedge PCLK);
    total++; if (data !== 1'b0) $display("FAIL pre_reset_line got %b want 0", data); else passed++;
    #2 PRESERN = 1;
    #1;
    total++; if (data !== 1'b1) $display("FAIL async_reset_line got %b want 1", data); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL async_reset_ready got %b want 0", ready); else passed++;
    @(negedge PCLK); PRESERN = 0;
    apb_read(32'h0, r);
    total++; if (r !== 32'h0) $display("FAIL post_reset_ctrl got %h want 0", r); else passed++;
    apb_read(32'h4, r);
    total++; if (r !== 32'h0) $display("FAIL post_reset_status got %h want 0", r); else passed++;
  endtask

  initial begin
    test_reset();
    test_tx_timing();
    test_timeout();
    test_rumble_and_response();
    test_disable_in_rx();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
